// File: rtl/fwd_hazard_ctrl.sv
// Forwarding/hazard control for the RV32I pipeline; operand selects registered at ID->EX (1 edge), dcache select at EX->MEM.
// Backpressure: stall_i freezes all records/outputs; hazard_stall is combinational and requests one bubble into EX.
module fwd_hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall_i,
    input  logic       flush_i,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] id_rd,
    input  logic [2:0] id_regfilemux_sel,
    input  logic       id_store,
    output logic [2:0] ex_rs1mux_sel,
    output logic [2:0] ex_rs2mux_sel,
    output logic       mem_dcachemux_sel,
    output logic       hazard_stall
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic [2:0] wbsel;
        logic       store;
        logic       st_fwd;
    } stage_rec_t;

    localparam logic [2:0] WB_ALU   = 3'b000;
    localparam logic [2:0] WB_BR    = 3'b001;
    localparam logic [2:0] WB_UIMM  = 3'b010;
    localparam logic [2:0] WB_LOAD  = 3'b011;
    localparam logic [2:0] WB_PC4   = 3'b100;

    localparam logic [2:0] SEL_RS      = 3'b000;
    localparam logic [2:0] SEL_EX_ALU  = 3'b001;
    localparam logic [2:0] SEL_EX_BR   = 3'b010;
    localparam logic [2:0] SEL_RFMUX   = 3'b011;
    localparam logic [2:0] SEL_EX_UIMM = 3'b101;

    stage_rec_t ex_q, mem_q, wb_q;
    stage_rec_t ex_next;

    logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    logic ex_late, st_fwd_case, raw_hazard, accept;
    logic [2:0] rs1_sel_next, rs2_sel_next;

    // A producer in EX already has its value on the EX/MEM latch only for
    // ALU/branch/U-imm results; loads and link values are not ready yet.
    function automatic logic [2:0] fwd_sel(input logic ex_hit, input logic mem_hit,
                                           input logic [2:0] ex_wbsel);
        logic [2:0] sel;
        sel = SEL_RS;
        if (ex_hit) begin
            case (ex_wbsel)
                WB_ALU:  sel = SEL_EX_ALU;
                WB_BR:   sel = SEL_EX_BR;
                WB_UIMM: sel = SEL_EX_UIMM;
                default: sel = SEL_RS;
            endcase
        end else if (mem_hit) begin
            sel = SEL_RFMUX;
        end
        return sel;
    endfunction

    always_comb begin
        ex_hit1  = ex_q.valid  && (ex_q.rd  != 5'd0) && (ex_q.rd  == id_rs1) && id_use_rs1;
        ex_hit2  = ex_q.valid  && (ex_q.rd  != 5'd0) && (ex_q.rd  == id_rs2) && id_use_rs2;
        mem_hit1 = mem_q.valid && (mem_q.rd != 5'd0) && (mem_q.rd == id_rs1) && id_use_rs1;
        mem_hit2 = mem_q.valid && (mem_q.rd != 5'd0) && (mem_q.rd == id_rs2) && id_use_rs2;

        ex_late = (ex_q.wbsel == WB_LOAD) || (ex_q.wbsel == WB_PC4);

        // Load feeding only store data: let the store proceed and pick the
        // loaded value up from the regfile mux once the store reaches MEM.
        st_fwd_case = ex_hit2 && !ex_hit1 && id_store && (ex_q.wbsel == WB_LOAD);

        raw_hazard   = ex_late && (ex_hit1 || ex_hit2) && !st_fwd_case;
        hazard_stall = id_valid && !flush_i && raw_hazard;
        accept       = id_valid && !flush_i && !raw_hazard;

        rs1_sel_next = fwd_sel(ex_hit1, mem_hit1, ex_q.wbsel);
        rs2_sel_next = fwd_sel(ex_hit2, mem_hit2, ex_q.wbsel);

        ex_next = '0;
        if (accept) begin
            ex_next.valid  = 1'b1;
            ex_next.rd     = id_rd;
            ex_next.wbsel  = id_regfilemux_sel;
            ex_next.store  = id_store;
            ex_next.st_fwd = st_fwd_case;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q              <= '0;
            mem_q             <= '0;
            wb_q              <= '0;
            ex_rs1mux_sel     <= SEL_RS;
            ex_rs2mux_sel     <= SEL_RS;
            mem_dcachemux_sel <= 1'b0;
        end else if (!stall_i) begin
            wb_q              <= mem_q;
            mem_q             <= ex_q;
            ex_q              <= ex_next;
            ex_rs1mux_sel     <= accept ? rs1_sel_next : SEL_RS;
            ex_rs2mux_sel     <= accept ? rs2_sel_next : SEL_RS;
            mem_dcachemux_sel <= ex_q.st_fwd;
        end
    end

    // WB is tracked for visibility only; the write-through regfile means it never forwards.
    logic unused_rec;
    assign unused_rec = ^{wb_q, mem_q.wbsel, mem_q.store, mem_q.st_fwd, ex_q.store};

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and hazard controller for the 5-stage pipelined RV32I core. It tracks the destination register and write-back source of the instructions in EX, MEM and WB, and registers the `rs1mux`/`rs2mux` select codes for the instruction entering EX. It produces the MEM-stage `dcachemux` select and raises the load-use / link-use stall request. It sits between decode and the datapath muxes, and drives the select enums the datapath consumes.

## Interface
- No parameters; widths are fixed by RV32I (5-bit register index, 3-bit select codes).
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset is asynchronous and active-low.
- `stall_i` in 1: global freeze from the I-/D-cache; holds all internal state.
- `flush_i` in 1: taken branch/jump resolved in EX; the ID instruction must not enter EX.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs1`, `id_rs2` in 5: source registers.
- `id_use_rs1`, `id_use_rs2` in 1: source actually read.
- `id_rd` in 5: destination register; x0 means no write.
- `id_regfilemux_sel` in 3: write-back source code. alu_out=000, br_en=001, u_imm=010, MDRreg_out=011, pc_plus4=100. Code 011 marks a load.
- `id_store` in 1: ID instruction is a store; rs2 is store data.
- `ex_rs1mux_sel`, `ex_rs2mux_sel` out 3: registered EX operand selects. rs1_out=000, exmem_alu_out=001, exmem_br_en=010, regfilemux_out=011, exmem_u_imm=101. mem_rdata=100 is never emitted.
- `mem_dcachemux_sel` out 1: registered MEM store-data select. rs2_out=0, regfilemux_out=1.
- `hazard_stall` out 1: combinational; hold PC/IF/ID and insert a bubble into EX.

## Operation
- Stage records EX, MEM and WB each hold {valid, rd, wbsel, store, st_fwd}.
- A producer matches a consumer source when it is valid, its rd≠0, its rd equals the source register, and the matching `id_use_*` is set.
- `hazard_stall` = id_valid & !flush_i & (EX producer matches rs1 or rs2 with wbsel ∈ {011, 100}).
  - Exception: if only rs2 matches, `id_store`=1 and EX wbsel=011, there is no stall. Instead set st_fwd for that store.
- Select for each source is computed at ID→EX, first match wins:
  1. EX producer matches: wbsel 000→001, 001→010, 010→101.
  2. MEM producer matches (any wbsel) → 011.
  3. Otherwise → 000.
- A WB-stage producer needs no forwarding: the regfile is write-through.
- On a load→store-data (st_fwd) case, `ex_rs2mux_sel` is 000; the data arrives via `mem_dcachemux_sel`=1 in MEM.
- Each edge with `stall_i`=0:
  - WB←MEM, MEM←EX.
  - EX←ID record if id_valid & !flush_i & !hazard_stall; otherwise EX←bubble (valid=0, selects 000, st_fwd=0).
  - `ex_*mux_sel` load together with EX.
  - `mem_dcachemux_sel` ← EX.st_fwd.
- With `stall_i`=1, all records and outputs hold. `hazard_stall` still evaluates combinationally but changes no state.
- `flush_i` and `hazard_stall` together: flush wins, a bubble enters EX, and `hazard_stall` is forced to 0.

## Timing
- Reset (rst=0, asynchronous): all valid bits and st_fwd = 0, all select outputs = 000/0, `hazard_stall` = 0. Reset mid-pipeline discards every record immediately.
- Select latency: the codes appear on the first edge after the instruction is accepted from ID, and are valid for that instruction's whole EX residency, including frozen cycles.
- Load-use or pc_plus4-use: exactly one bubble. On the next cycle the producer is in MEM and the consumer gets 011.
- rd=x0 never forwards and never stalls.
- Back-to-back producers to the same rd: the EX (younger) producer takes priority over MEM.

## Test plan
- `add x5` then `sub x6,x5,x1` → on the sub's EX cycle `ex_rs1mux_sel`=001, `hazard_stall` never asserts.
- `lw x7` then `add x8,x7,x7` → `hazard_stall`=1 for 1 cycle, one bubble, then both selects=011.
- `lw x9` then `sw x9,0(x2)` → no stall; `ex_rs2mux_sel`=000; one cycle later `mem_dcachemux_sel`=1.
- `lui x3`, `nop`, `addi x4,x3,1` → rs1 select=011. With `lui x3` directly followed by `addi x4,x3,1` → rs1 select=101.
- `flush_i` pulsed while ID has a load-use hazard → `hazard_stall`=0, EX bubble, selects 000. `stall_i` held 3 cycles mid-sequence → outputs frozen.
- `rst` asserted asynchronously with EX/MEM valid → outputs 000/0 before the next edge; `add x0` producer → consumer select 000.
